// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit sll/sra unit: one power-of-two stage per cycle (1,2,4,8,16).
// Latency: 5 cycles from the accepting edge to the one-cycle data_resultRDY pulse; 1 result per 6 cycles.
// Backpressure: none; ctrl_start is ignored while busy and accepted only in IDLE or DONE.
module shift_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_start,
    input  logic        ctrl_op,
    input  logic [4:0]  ctrl_shamt,
    input  logic [31:0] data_operandA,
    output logic [31:0] data_result,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  k;
    logic [31:0] acc;
    logic [4:0]  shamt_q;
    logic        op_q;

    logic [4:0]  stage_amt;
    logic        stage_en;
    logic [31:0] stage_out;

    // stage_amt is one-hot at bit k, so it doubles as both the shift distance and the shamt bit select.
    always_comb begin
        stage_amt = 5'd0;
        case (k)
            3'd0:    stage_amt = 5'd1;
            3'd1:    stage_amt = 5'd2;
            3'd2:    stage_amt = 5'd4;
            3'd3:    stage_amt = 5'd8;
            3'd4:    stage_amt = 5'd16;
            default: stage_amt = 5'd0;
        endcase
        stage_en  = |(shamt_q & stage_amt);
        stage_out = acc;
        if (stage_en) begin
            if (op_q)
                stage_out = $signed(acc) >>> stage_amt;
            else
                stage_out = acc << stage_amt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            k              <= 3'd0;
            acc            <= 32'd0;
            shamt_q        <= 5'd0;
            op_q           <= 1'b0;
            data_result    <= 32'd0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    data_resultRDY <= 1'b0;
                    if (ctrl_start) begin
                        acc     <= data_operandA;
                        op_q    <= ctrl_op;
                        shamt_q <= ctrl_shamt;
                        k       <= 3'd0;
                        state   <= SHIFT;
                        busy    <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                SHIFT: begin
                    acc <= stage_out;
                    if (k == 3'd4) begin
                        data_result    <= stage_out;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= DONE;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    data_resultRDY <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule
